// File: rtl/tdr_cmd_rx.sv
// tdr_cmd_rx: UART command receiver driving the TDR line-simulator controls.
// Optional macro TDR_CMD_RX_PARITY_EN selects 8E1 framing (default build 8N1).
module tdr_cmd_rx #(
    parameter int         CLKS_PER_BIT  = 868,
    parameter logic [1:0] DEFAULT_TYPE  = 2'b10,
    parameter logic [3:0] DEFAULT_DELAY = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       trigger,
    output logic [1:0] reflect_type,
    output logic [3:0] reflect_delay,
    output logic       cfg_update,
    output logic       rx_error
);

    localparam int         CW   = 16;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef TDR_CMD_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } rx_state_t;
`endif

    typedef enum logic {
        D_CMD, D_ARG
    } dec_state_t;

    rx_state_t  state;
    dec_state_t dstate;

    logic          sync1;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          stop_wait;
    logic          byte_ok;
    logic          byte_bad;
    logic          stop_good;
`ifdef TDR_CMD_RX_PARITY_EN
    logic          par_bad;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rxs   <= sync1;
        end
    end

    // A frame is accepted only with a high stop bit (and matching parity)
    always_comb begin
`ifdef TDR_CMD_RX_PARITY_EN
        stop_good = rxs & ~par_bad;
`else
        stop_good = rxs;
`endif
    end

    // Receiver: mid-bit sampling driven by the synchronized line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            stop_wait <= 1'b0;
            byte_ok   <= 1'b0;
            byte_bad  <= 1'b0;
`ifdef TDR_CMD_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt    <= '0;
                    bitcnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL) begin
                        cnt    <= '0;
                        shreg  <= {rxs, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
`ifdef TDR_CMD_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef TDR_CMD_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        par_bad <= rxs != (^shreg);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (stop_wait) begin
                        if (rxs) begin
                            stop_wait <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else if (cnt == FULL) begin
                        cnt <= '0;
                        if (stop_good) begin
                            byte_ok <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            byte_bad <= 1'b1;
                            if (rxs) state <= S_IDLE;
                            else stop_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Command decoder: 'T' fires trigger, 'C' takes one config argument byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate        <= D_CMD;
            trigger       <= 1'b0;
            cfg_update    <= 1'b0;
            rx_error      <= 1'b0;
            reflect_type  <= DEFAULT_TYPE;
            reflect_delay <= DEFAULT_DELAY;
        end else begin
            trigger    <= 1'b0;
            cfg_update <= 1'b0;
            if (byte_ok) begin
                case (dstate)
                    D_CMD: begin
                        if (shreg == 8'h54) trigger <= 1'b1;
                        else if (shreg == 8'h43) dstate <= D_ARG;
                        else rx_error <= 1'b1;
                    end
                    D_ARG: begin
                        reflect_type  <= shreg[5:4];
                        reflect_delay <= shreg[3:0];
                        cfg_update    <= 1'b1;
                        dstate        <= D_CMD;
                    end
                    default: dstate <= D_CMD;
                endcase
            end else if (byte_bad) begin
                rx_error <= 1'b1;
                dstate   <= D_CMD;
            end
        end
    end

endmodule
